// File: rtl/joypad_pkg.sv
// Shared types and constants for the multiplexed joypad hub.
package joypad_pkg;

  // Scanner phases: select low, select high, then one commit cycle.
  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_HIGH   = 2'd1,
    S_COMMIT = 2'd2
  } scan_state_t;

  // One frame holds both halves of a six-pin pad: [5:0] half A, [11:6] half B.
  localparam int C_frame_bits = 12;

  // Number of report bits that have a button behind them.
  localparam int C_map_bits = 8;

  // Frame index for each report bit: A, B, Select, Start, Up, Down, Left, Right.
  localparam logic [3:0] C_report_map [C_map_bits] = '{
    4'd11, 4'd10, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9
  };

  // A connected pad ties half A pins 2 and 3 low.
  localparam logic [3:0] C_present_bits [2] = '{4'd2, 4'd3};

endpackage

// File: rtl/joypad_channel.sv
// One pad: frame debounce, report mapping, presence flag and the serial
// strobe/read shifter seen by the CPU.
//
// Handshake: load is a level; while it is high the shifter reloads every
// cycle and rden is ignored. With load low, every cycle rden is high shifts
// the report one bit towards data, filling with 1.
module joypad_channel
  import joypad_pkg::*;
#(
  parameter int P_report_bits = 8,
  parameter int P_debounce    = 4
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    commit,
  input  logic [C_frame_bits-1:0] frame,
  input  logic                    load,
  input  logic                    rden,
  output logic                    data,
  output logic                    present
);

  localparam int C_cnt_bits = $clog2(P_debounce + 1);
  localparam logic [C_cnt_bits-1:0] C_cnt_max = C_cnt_bits'(P_debounce);

  logic [C_frame_bits-1:0]  candidate;
  logic [C_frame_bits-1:0]  candidate_next;
  logic [C_frame_bits-1:0]  stable;
  logic [C_cnt_bits-1:0]    count;
  logic [C_cnt_bits-1:0]    count_next;
  logic [P_report_bits-1:0] report;
  logic [P_report_bits-1:0] shreg;

  // Candidate/run-length update for the frame offered in this commit.
  always_comb begin
    candidate_next = candidate;
    count_next     = count;
    if (frame == candidate) begin
      if (count != C_cnt_max) count_next = count + 1'b1;
    end else begin
      candidate_next = frame;
      count_next     = C_cnt_bits'(1);
    end
  end

  // Debounce registers; stable only moves once the run reaches P_debounce.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      candidate <= '0;
      count     <= '0;
      stable    <= '0;
    end else if (commit) begin
      candidate <= candidate_next;
      count     <= count_next;
      if (count_next == C_cnt_max) stable <= candidate_next;
    end
  end

  // Report bits beyond the button map read as released.
  for (genvar i = 0; i < P_report_bits; i++) begin : g_map
    if (i < C_map_bits) begin : g_bit
      assign report[i] = stable[C_report_map[i]];
    end else begin : g_pad
      assign report[i] = 1'b0;
    end
  end

  assign present = stable[C_present_bits[0]] & stable[C_present_bits[1]];

  // Serial shifter: load wins over rden; reads past the end return 1.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= report;
    end else if (rden) begin
      shreg <= {1'b1, shreg[P_report_bits-1:1]};
    end
  end

  assign data = load ? report[0] : shreg[0];

endmodule

// File: rtl/joypad_hub.sv
// Multi-port joypad hub: one shared select-line scanner feeding a
// debounce/report/shift channel per pad port.
module joypad_hub
  import joypad_pkg::*;
#(
  parameter int P_channels    = 2,
  parameter int P_pin_bits    = 6,   // must be 6: one half of a 12-bit frame
  parameter int P_report_bits = 8,
  parameter int P_settle      = 8,   // minimum 1
  parameter int P_debounce    = 4    // minimum 1
) (
  input  logic                             I_clock,
  input  logic                             I_reset,
  input  logic [P_channels*P_pin_bits-1:0] I_joy_bits,
  output logic [P_channels-1:0]            O_joy_mode,
  input  logic [P_channels-1:0]            I_GPIO_load,
  input  logic [P_channels-1:0]            I_GPIO_rden,
  output logic [P_channels-1:0]            O_GPIO_data,
  output logic [P_channels-1:0]            O_present
);

  localparam int C_settle_bits = $clog2(P_settle + 1);
  localparam logic [C_settle_bits-1:0] C_settle_last = C_settle_bits'(P_settle);

  scan_state_t                      state;
  scan_state_t                      state_next;
  logic [C_settle_bits-1:0]         settle_cnt;
  logic                             settle_done;
  logic                             mode;
  logic                             sample_a;
  logic                             sample_b;
  logic                             commit;
  logic [P_channels*P_pin_bits-1:0] half_a;
  logic [P_channels*P_pin_bits-1:0] half_b;

  assign settle_done = (settle_cnt == C_settle_last);

  // State register; the settle counter restarts on every state entry.
  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      state      <= S_LOW;
      settle_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) settle_cnt <= '0;
      else                     settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Next state: each select level is held P_settle+1 cycles, then one commit.
  always_comb begin
    state_next = state;
    case (state)
      S_LOW:    if (settle_done) state_next = S_HIGH;
      S_HIGH:   if (settle_done) state_next = S_COMMIT;
      S_COMMIT: state_next = S_LOW;
      default:  state_next = S_LOW;
    endcase
  end

  // Outputs: select level, sample strobes on the last settle cycle, commit.
  always_comb begin
    mode     = 1'b0;
    sample_a = 1'b0;
    sample_b = 1'b0;
    commit   = 1'b0;
    case (state)
      S_LOW:    sample_a = settle_done;
      S_HIGH: begin
        mode     = 1'b1;
        sample_b = settle_done;
      end
      S_COMMIT: commit = 1'b1;
      default:  ;
    endcase
  end

  // Raw half captures; reset returns them to the released (all-high) level.
  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      half_a <= '1;
      half_b <= '1;
    end else begin
      if (sample_a) half_a <= I_joy_bits;
      if (sample_b) half_b <= I_joy_bits;
    end
  end

  assign O_joy_mode = {P_channels{mode}};

  for (genvar n = 0; n < P_channels; n++) begin : g_chan
    logic [C_frame_bits-1:0] frame;

    // Pins are active-low; the frame stores 1 = pressed.
    assign frame = ~{half_b[n*P_pin_bits +: P_pin_bits],
                     half_a[n*P_pin_bits +: P_pin_bits]};

    joypad_channel #(
      .P_report_bits (P_report_bits),
      .P_debounce    (P_debounce)
    ) u_chan (
      .clock   (I_clock),
      .rst_n   (I_reset),
      .commit  (commit),
      .frame   (frame),
      .load    (I_GPIO_load[n]),
      .rden    (I_GPIO_rden[n]),
      .data    (O_GPIO_data[n]),
      .present (O_present[n])
    );
  end

endmodule

// File: tb/tb_joypad_hub.sv
// Bench for joypad_hub with four pad ports. Pads are emulated from the select
// line; a cycle-level reference model of scan timing, debounce history and
// the serial report checks every output each cycle, alongside directed tables.
module tb_joypad_hub;

  localparam int NCH  = 4;
  localparam int PINS = 6;
  localparam int RB   = 8;
  localparam int SETTLE = 8;
  localparam int DB   = 4;
  localparam int T    = 2*SETTLE + 3;
  localparam int MAP [8] = '{11, 10, 4, 5, 6, 7, 8, 9};

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH*PINS-1:0] joy_bits;
  logic [NCH-1:0] joy_mode, load, rden, gpio_data, present;

  always #5 clk = ~clk;

  joypad_hub #(
    .P_channels(NCH), .P_pin_bits(PINS), .P_report_bits(RB),
    .P_settle(SETTLE), .P_debounce(DB)
  ) dut (
    .I_clock(clk), .I_reset(rst_n), .I_joy_bits(joy_bits),
    .O_joy_mode(joy_mode), .I_GPIO_load(load), .I_GPIO_rden(rden),
    .O_GPIO_data(gpio_data), .O_present(present)
  );

  // Pad emulation: a multiplexed pad presents half B while select is high.
  logic [5:0] pad_a [NCH];
  logic [5:0] pad_b [NCH];

  always_comb begin
    for (int c = 0; c < NCH; c++)
      joy_bits[c*PINS +: PINS] = joy_mode[c] ? pad_b[c] : pad_a[c];
  end

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RB-1:0] report_of(input logic [11:0] f);
    logic [RB-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = f[MAP[i]];
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Edges since reset decide the scan phase; debounce keeps the last DB frames.
  int          n_edges;
  logic [5:0]  m_half_a [NCH];
  logic [5:0]  m_half_b [NCH];
  logic [11:0] hist [NCH][DB];
  int          n_hist [NCH];
  logic [11:0] m_stable [NCH];
  logic [RB-1:0] snap [NCH];
  int          rd_idx [NCH];

  always @(posedge clk) begin
    if (!rst_n) begin
      n_edges = 0;
      for (int c = 0; c < NCH; c++) begin
        n_hist[c] = 0;
        m_stable[c] = '0;
        snap[c] = '0;
        rd_idx[c] = 0;
      end
    end else begin
      n_edges++;
      for (int c = 0; c < NCH; c++) begin
        if (load[c]) begin
          snap[c] = report_of(m_stable[c]);
          rd_idx[c] = 0;
        end else if (rden[c] && rd_idx[c] < RB) begin
          rd_idx[c]++;
        end
      end
      if (n_edges % T == SETTLE + 1)
        for (int c = 0; c < NCH; c++) m_half_a[c] = pad_a[c];
      if (n_edges % T == 2*SETTLE + 2)
        for (int c = 0; c < NCH; c++) m_half_b[c] = pad_b[c];
      if (n_edges % T == 0) begin
        for (int c = 0; c < NCH; c++) begin
          logic [11:0] f;
          bit same;
          f = ~{m_half_b[c], m_half_a[c]};
          for (int k = DB-1; k > 0; k--) hist[c][k] = hist[c][k-1];
          hist[c][0] = f;
          if (n_hist[c] < DB) n_hist[c]++;
          same = 1'b1;
          for (int k = 0; k < DB; k++) if (hist[c][k] != f) same = 1'b0;
          if (n_hist[c] == DB && same) m_stable[c] = f;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  int            ck_p;
  logic          ck_mode;
  logic          ck_data;
  logic [RB-1:0] ck_rep;

  always @(negedge clk) begin
    #4;
    if (chk_en) begin
      ck_p = n_edges % T;
      ck_mode = (ck_p >= SETTLE + 1) && (ck_p <= 2*SETTLE + 1);
      check("mode", joy_mode, {NCH{ck_mode}});
      for (int c = 0; c < NCH; c++) begin
        ck_rep = report_of(m_stable[c]);
        if (load[c])          ck_data = ck_rep[0];
        else if (rd_idx[c] < RB) ck_data = snap[c][rd_idx[c]];
        else                  ck_data = 1'b1;
        check($sformatf("data_ch%0d", c), gpio_data[c], ck_data);
        check($sformatf("present_ch%0d", c), present[c], m_stable[c][2] & m_stable[c][3]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [15:0] got_bits [NCH];
  logic exp_q [$];

  task automatic press(input int c, input logic [11:0] raw);
    pad_a[c] = raw[5:0];
    pad_b[c] = raw[11:6];
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe the masked channels, then read nreads bits on consecutive cycles.
  task automatic read_bits(input logic [NCH-1:0] mask, input int nreads);
    @(negedge clk);
    load = load | mask;
    @(negedge clk);
    load = load & ~mask;
    rden = rden | mask;
    for (int i = 0; i < nreads; i++) begin
      #1;
      for (int c = 0; c < NCH; c++) got_bits[c][i] = gpio_data[c];
      @(negedge clk);
    end
    rden = rden & ~mask;
  endtask

  task automatic expect_report(input int c, input string name, input logic [7:0] rep, input int nreads);
    for (int i = 0; i < 8; i++) exp_q.push_back(rep[i]);
    for (int i = 8; i < nreads; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < nreads; i++) begin
      logic e;
      e = exp_q.pop_front();
      check($sformatf("%s_ch%0d_bit%0d", name, c, i), got_bits[c][i], e);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [11:0] raw;
    logic [7:0]  rep;
    logic        pres;
  } vec_t;
  vec_t vecs [12];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{12'hFFF, 8'h00, 1'b0};
    vecs[1]  = '{12'h7FF, 8'h01, 1'b0};
    vecs[2]  = '{12'hBFF, 8'h02, 1'b0};
    vecs[3]  = '{12'hFEF, 8'h04, 1'b0};
    vecs[4]  = '{12'hFDF, 8'h08, 1'b0};
    vecs[5]  = '{12'hFBF, 8'h10, 1'b0};
    vecs[6]  = '{12'hF7F, 8'h20, 1'b0};
    vecs[7]  = '{12'hEFF, 8'h40, 1'b0};
    vecs[8]  = '{12'hDFF, 8'h80, 1'b0};
    vecs[9]  = '{12'hFF3, 8'h00, 1'b1};
    vecs[10] = '{12'h000, 8'hFF, 1'b1};
    vecs[11] = '{12'hFFC, 8'h00, 1'b0};

    // Reset with strobe high and random pins.
    load = '1;
    rden = '0;
    for (int c = 0; c < NCH; c++) press(c, 12'($urandom));
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("reset_mode", joy_mode, '0);
      check("reset_data", gpio_data, '0);
      check("reset_present", present, '0);
    end
    load = '0;
    for (int c = 0; c < NCH; c++) press(c, 12'hFFF);
    rst_n = 1'b1;

    // Mapping table on channel 0; 10 reads show the 1-fill after the report.
    for (int v = 0; v < 12; v++) begin
      press(0, vecs[v].raw);
      wait_cycles((DB + 1) * T);
      check($sformatf("table%0d_present", v), present[0], vecs[v].pres);
      read_bits(4'b0001, 10);
      expect_report(0, $sformatf("table%0d", v), vecs[v].rep, 10);
    end

    // Glitch rejection on Select, then a four-scan hold that commits.
    press(0, 12'hFFF);
    wait_cycles((DB + 1) * T);
    pad_a[0][4] = 1'b0;
    wait_cycles(T);
    pad_a[0][4] = 1'b1;
    wait_cycles((DB + 1) * T);
    read_bits(4'b0001, 3);
    check("glitch_select", got_bits[0][2], 1'b0);
    pad_a[0][4] = 1'b0;
    wait_cycles(4 * T);
    pad_a[0][4] = 1'b1;
    wait_cycles(12);
    read_bits(4'b0001, 3);
    check("hold4_select", got_bits[0][2], 1'b1);

    // Strobe held high: reads are ignored, bit0 follows the commit of A.
    press(0, 12'hFFF);
    wait_cycles((DB + 1) * T);
    load[0] = 1'b1;
    press(0, 12'h7FF);
    #1;
    check("strobe_before", gpio_data[0], 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rden[0] = 1'b1;
      @(negedge clk);
      rden[0] = 1'b0;
      #1;
      check($sformatf("strobe_hold%0d", k), gpio_data[0], 1'b0);
    end
    wait_cycles((DB + 1) * T);
    check("strobe_after", gpio_data[0], 1'b1);
    load[0] = 1'b0;

    // Channel independence.
    press(0, 12'hFFF);
    press(1, 12'hFFF);
    press(2, 12'hFDF);
    press(3, 12'hDFF);
    wait_cycles((DB + 1) * T);
    read_bits(4'b1111, 8);
    expect_report(0, "indep", 8'h00, 8);
    expect_report(1, "indep", 8'h00, 8);
    expect_report(2, "indep", 8'h08, 8);
    expect_report(3, "indep", 8'h80, 8);

    // Presence, then reset during the select-high phase.
    press(0, 12'hFF3);
    wait_cycles((DB + 1) * T);
    #1;
    check("present_set", present[0], 1'b1);
    for (int k = 0; k < 2*T && !joy_mode[0]; k++) @(negedge clk);
    check("mode_high_seen", joy_mode[0], 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midscan_mode", joy_mode[0], 1'b0);
    check("midscan_present", present[0], 1'b0);
    for (int k = 1; k < DB * T; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("present_low_%0d", k), present[0], 1'b0);
    end
    @(negedge clk);
    #1;
    check("present_reassert", present[0], 1'b1);

    // Randomized pads, strobes and reads against the model.
    for (int it = 0; it < 40; it++) begin
      int hold;
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 3))
          0: press(c, 12'hFFF);
          1: press(c, ~(12'h001 << $urandom_range(0, 11)));
          2: press(c, 12'($urandom));
          default: ;
        endcase
      end
      hold = $urandom_range(1, 5 * T);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
          load[c] = ($urandom_range(0, 7) == 0);
          rden[c] = 1'($urandom_range(0, 1));
        end
      end
    end
    @(negedge clk);
    load = '0;
    rden = '0;
    wait_cycles(4);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
